// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared definitions for the VGA sync receiver.
//   rx_state_t      lock FSM encoding (SEARCH, MEASURE, LOCKED)
//   DEF_CNT_W       default horizontal counter / period measurement width
//   DEF_LINE_W      default line counter / lines-per-frame width
//   DEF_PERIOD_TOL  default allowed line-period jitter in clocks
//   RED_W           width of the per-frame red-pixel counter
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

  localparam int DEF_CNT_W      = 12;
  localparam int DEF_LINE_W     = 10;
  localparam int DEF_PERIOD_TOL = 1;
  localparam int RED_W          = 20;

endpackage

// File: rtl/vga_sync_receiver_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer followed by a registered edge detector.
//   Clock   in   system clock
//   Reset   in   synchronous, active-high; every stage resets to the idle-high
//                level so leaving reset never produces a spurious edge
//   iAsync  in   asynchronous input
//   oLevel  out  synchronized level (2 clocks behind the pin)
//   oRise   out  one-clock pulse, 3 clocks after a pin rising edge
//   oFall   out  one-clock pulse, 3 clocks after a pin falling edge
module sync_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic iAsync,
  output logic oLevel,
  output logic oRise,
  output logic oFall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      prev  <= 1'b1;
      oRise <= 1'b0;
      oFall <= 1'b0;
    end else begin
      meta  <= iAsync;
      sync  <= meta;
      prev  <= sync;
      oRise <= sync & ~prev;
      oFall <= ~sync & prev;
    end
  end

  assign oLevel = sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: measures incoming VGA sync timing, recovers pixel/line
// coordinates and declares lock once the timing repeats over two frames.
//   Clock           in   system clock (sync inputs are asynchronous to it)
//   Reset           in   synchronous, active-high
//   iHsync/iVsync   in   active-low syncs
//   iRed            in   red level, only used with VGA_RX_RED_COUNT_EN
//   oPixelX         out  clocks since last Hsync fall (saturates)
//   oLineY          out  Hsync falls since last Vsync fall (saturates)
//   oLinePeriod     out  last Hsync fall-to-fall period
//   oHsyncWidth     out  last Hsync low time
//   oLinesPerFrame  out  lines in the last complete frame
//   oLocked         out  timing stable
//   oErr            out  one-clock pulse when lock is lost
//   oRedCount       out  red-high cycles in the last frame (0 unless
//                        VGA_RX_RED_COUNT_EN is defined)
// Optional feature macro: VGA_RX_RED_COUNT_EN.
// The lock FSM state is the internal signal "state" (type rx_state_t).
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LINE_W     = DEF_LINE_W,
  parameter int PERIOD_TOL = DEF_PERIOD_TOL
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iHsync,
  input  logic              iVsync,
  input  logic              iRed,
  output logic [CNT_W-1:0]  oPixelX,
  output logic [LINE_W-1:0] oLineY,
  output logic [CNT_W-1:0]  oLinePeriod,
  output logic [CNT_W-1:0]  oHsyncWidth,
  output logic [LINE_W-1:0] oLinesPerFrame,
  output logic              oLocked,
  output logic              oErr,
  output logic [RED_W-1:0]  oRedCount
);

  localparam logic [CNT_W-1:0]  H_ONE = CNT_W'(1);
  localparam logic [LINE_W-1:0] V_ONE = LINE_W'(1);
  localparam logic [CNT_W-1:0]  TOL_C = CNT_W'(PERIOD_TOL);

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise_unused, vs_fall;

  sync_edge_detect u_hs (
    .Clock (Clock), .Reset (Reset), .iAsync (iHsync),
    .oLevel(hs_lvl), .oRise(hs_rise), .oFall(hs_fall)
  );

  sync_edge_detect u_vs (
    .Clock (Clock), .Reset (Reset), .iAsync (iVsync),
    .oLevel(vs_lvl), .oRise(vs_rise_unused), .oFall(vs_fall)
  );

  // Counters and measurements
  logic [CNT_W-1:0]  hcnt;
  logic [LINE_W-1:0] vcnt;
  logic [CNT_W-1:0]  ref_period;
  logic [LINE_W-1:0] ref_lines;
  logic              hcnt_max;
  logic [CNT_W-1:0]  hcnt_inc;
  logic [LINE_W-1:0] vcnt_inc;
  logic              ref_load;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign hcnt_max = &hcnt;
  // hcnt_inc doubles as "period ending now": hcnt+1, held at all-ones.
  assign hcnt_inc = hcnt_max ? hcnt : hcnt + H_ONE;
  assign vcnt_inc = (&vcnt) ? vcnt : vcnt + V_ONE;

  logic prev_bad;
  logic ref_bad;
  assign prev_bad = abs_diff(hcnt_inc, oLinePeriod) > TOL_C;
  assign ref_bad  = abs_diff(hcnt_inc, ref_period) > TOL_C;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hcnt           <= '0;
      vcnt           <= '0;
      oLinePeriod    <= '0;
      oHsyncWidth    <= '0;
      oLinesPerFrame <= '0;
      ref_period     <= '0;
      ref_lines      <= '0;
    end else begin
      if (hs_fall) begin
        oLinePeriod <= hcnt_inc;
        hcnt        <= '0;
      end else begin
        if (hs_rise) oHsyncWidth <= hcnt_inc;
        hcnt <= hcnt_inc;
      end
      // vs_fall wins over a coincident hs_fall for the line counter.
      if (vs_fall) begin
        oLinesPerFrame <= vcnt;
        vcnt           <= '0;
      end else if (hs_fall) begin
        vcnt <= vcnt_inc;
      end
      if (ref_load) begin
        ref_period <= hs_fall ? hcnt_inc : oLinePeriod;
        ref_lines  <= vcnt;
      end
    end
  end

  assign oPixelX = hcnt;
  assign oLineY  = vcnt;

  // Lock FSM: state register
  rx_state_t state, state_next;
  logic      mismatch, mismatch_next;
  logic      err_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_SEARCH;
      mismatch <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      state    <= state_next;
      mismatch <= mismatch_next;
      oErr     <= err_next;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_next    = state;
    mismatch_next = mismatch;
    err_next      = 1'b0;
    ref_load      = 1'b0;
    if (hcnt_max) begin
      // Hsync has gone away: start over from scratch.
      state_next = ST_SEARCH;
      err_next   = (state == ST_LOCKED);
    end else begin
      case (state)
        ST_SEARCH: begin
          mismatch_next = 1'b0;
          if (vs_fall) state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          // The first line of a frame has no in-frame predecessor to compare.
          if (hs_fall && (vcnt != '0) && prev_bad) mismatch_next = 1'b1;
          if (vs_fall) begin
            if (!mismatch && (vcnt == oLinesPerFrame)) begin
              state_next = ST_LOCKED;
              ref_load   = 1'b1;
            end
            mismatch_next = 1'b0;
          end
        end
        ST_LOCKED: begin
          if ((hs_fall && ref_bad) || (vs_fall && (vcnt != ref_lines))) begin
            err_next      = 1'b1;
            state_next    = ST_MEASURE;
            // The frame that broke lock cannot qualify for relock.
            mismatch_next = 1'b1;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  // Lock FSM: outputs
  always_comb begin
    oLocked = (state == ST_LOCKED);
  end

`ifdef VGA_RX_RED_COUNT_EN
  localparam logic [RED_W-1:0] RED_ONE = RED_W'(1);

  logic red_lvl, red_rise_unused, red_fall_unused;
  logic [RED_W-1:0] red_cnt;

  sync_edge_detect u_red (
    .Clock (Clock), .Reset (Reset), .iAsync (iRed),
    .oLevel(red_lvl), .oRise(red_rise_unused), .oFall(red_fall_unused)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      red_cnt   <= '0;
      oRedCount <= '0;
    end else if (vs_fall) begin
      oRedCount <= red_cnt;
      red_cnt   <= '0;
    end else if (red_lvl && hs_lvl && vs_lvl && !(&red_cnt)) begin
      red_cnt <= red_cnt + RED_ONE;
    end
  end
`else
  logic unused_in;
  assign unused_in = iRed ^ hs_lvl ^ vs_lvl;
  assign oRedCount = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
module tb_vga_sync_receiver;
  import vga_rx_pkg::*;

  localparam int P       = 800;   // line period in clocks
  localparam int W       = 96;    // Hsync low time
  localparam int L       = 6;     // lines per frame
  localparam int VS_LEAD = 8;     // Vsync falls this many clocks before a line start
  localparam int VS_LEN  = 2 * P; // Vsync low time

  // clock / reset
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic iHsync = 1'b1;
  logic iVsync = 1'b1;
  logic iRed = 1'b1;
  logic [11:0] oPixelX;
  logic [9:0]  oLineY;
  logic [11:0] oLinePeriod;
  logic [11:0] oHsyncWidth;
  logic [9:0]  oLinesPerFrame;
  logic        oLocked;
  logic        oErr;
  logic [19:0] oRedCount;

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  vga_sync_receiver dut (
    .Clock(Clock), .Reset(Reset), .iHsync(iHsync), .iVsync(iVsync), .iRed(iRed),
    .oPixelX(oPixelX), .oLineY(oLineY), .oLinePeriod(oLinePeriod),
    .oHsyncWidth(oHsyncWidth), .oLinesPerFrame(oLinesPerFrame),
    .oLocked(oLocked), .oErr(oErr), .oRedCount(oRedCount)
  );

  // event monitor on lock / error outputs
  logic lock_q = 1'b0;
  logic err_q = 1'b0;
  int lock_rise_cyc = -1, lock_fall_cyc = -1, lock_rises = 0;
  int err_rise_cyc = -1, err_pulses = 0, err_len = 0, err_max_len = 0, err_overlap = 0;

  always @(negedge Clock) begin
    if (oLocked === 1'b1 && lock_q === 1'b0) begin lock_rise_cyc = cyc; lock_rises++; end
    if (oLocked === 1'b0 && lock_q === 1'b1) lock_fall_cyc = cyc;
    if (oErr === 1'b1 && err_q === 1'b0) begin err_pulses++; err_rise_cyc = cyc; end
    if (oErr === 1'b1) begin
      err_len++;
      if (err_len > err_max_len) err_max_len = err_len;
      if (oLocked === 1'b1) err_overlap++;
    end else begin
      err_len = 0;
    end
    lock_q = oLocked;
    err_q  = oErr;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver: one pin update per clock, on the falling edge
  int vs_left = 0, vs_drive_cyc = -1, hs_drive_cyc = -1;
  int red_acc = 0, red_last = 0;

  task automatic step(input logic hs, input logic start_vs);
    @(negedge Clock);
    if (start_vs) begin vs_left = VS_LEN; vs_drive_cyc = cyc; end
    if (iHsync && !hs) hs_drive_cyc = cyc;
    iHsync = hs;
    iVsync = (vs_left > 0) ? 1'b0 : 1'b1;
    if (vs_left > 0) vs_left--;
    // pin-level model of the red counter: cycles with all three high between Vsync falls
    if (start_vs) begin red_last = red_acc; red_acc = 0; end
    else if (iHsync && iVsync && iRed) red_acc++;
  endtask

  task automatic line(input int p, input bit vs_end);
    for (int c = 0; c < p; c++) step(c >= W, vs_end && (c == p - VS_LEAD));
  endtask

  task automatic frame(input int bad_line, input bit jitter);
    for (int l = 0; l < L; l++) begin
      if (l == bad_line) line(P + 3, l == L - 1);
      else if (jitter) line((l % 2 == 1) ? P + 1 : P - 1, l == L - 1);
      else line(P, l == L - 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixelx"}, 32'(oPixelX), 0);
    check({tag, "_liney"}, 32'(oLineY), 0);
    check({tag, "_period"}, 32'(oLinePeriod), 0);
    check({tag, "_width"}, 32'(oHsyncWidth), 0);
    check({tag, "_lpf"}, 32'(oLinesPerFrame), 0);
    check({tag, "_locked"}, 32'(oLocked), 0);
    check({tag, "_err"}, 32'(oErr), 0);
    check({tag, "_red"}, 32'(oRedCount), 0);
  endtask

  int err_snap;

  initial begin
    // reset state
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    check("reset_state", 32'(dut.state), 32'(ST_SEARCH));
    Reset = 1'b0;

    // preamble with first Vsync fall, then two full frames -> lock on third Vsync fall
    for (int i = 0; i < 20; i++) step(1'b1, i == 12);
    frame(-1, 1'b0);
    frame(-1, 1'b0);
    check("meas_period", 32'(oLinePeriod), P);
    check("meas_width", 32'(oHsyncWidth), W);
    check("meas_lpf", 32'(oLinesPerFrame), L);
    check("meas_liney", 32'(oLineY), 0);
    check("meas_pixelx", 32'(oPixelX), 32'(cyc - hs_drive_cyc - 4));
    check("lock1_level", 32'(oLocked), 1);
    check("lock1_latency", 32'(lock_rise_cyc - vs_drive_cyc), 4);
    check("lock1_rises", 32'(lock_rises), 1);
    check("lock1_no_err", 32'(err_pulses), 0);

    // one long line (803) breaks lock
    frame(2, 1'b0);
    check("bad_err_pulses", 32'(err_pulses), 1);
    check("bad_err_width", 32'(err_max_len), 1);
    check("bad_err_overlap", 32'(err_overlap), 0);
    check("bad_lock_fall_with_err", 32'(lock_fall_cyc - err_rise_cyc), 0);
    check("bad_unlocked", 32'(oLocked), 0);
    check("bad_state", 32'(dut.state), 32'(ST_MEASURE));

    // steady frame relocks at the second Vsync fall after the error
    frame(-1, 1'b0);
    check("relock_level", 32'(oLocked), 1);
    check("relock_latency", 32'(lock_rise_cyc - vs_drive_cyc), 4);
`ifdef VGA_RX_RED_COUNT_EN
    check("red_count", 32'(oRedCount), 32'(red_last));
`else
    check("red_count", 32'(oRedCount), 0);
`endif

    // 799/801 jitter within tolerance keeps lock
    frame(-1, 1'b1);
    check("jitter_locked", 32'(oLocked), 1);
    check("jitter_no_err", 32'(err_pulses), 1);
    check("jitter_period", 32'(oLinePeriod), P - 1);

    // Hsync stops: counter saturates, FSM falls back to SEARCH
    repeat (4200) step(1'b1, 1'b0);
    check("stop_pixelx", 32'(oPixelX), 4095);
    check("stop_state", 32'(dut.state), 32'(ST_SEARCH));
    check("stop_err_pulses", 32'(err_pulses), 2);
    check("stop_err_width", 32'(err_max_len), 1);
    check("stop_unlocked", 32'(oLocked), 0);

    // resume: SEARCH -> MEASURE -> LOCKED over two frames
    frame(-1, 1'b0);
    check("resume_not_yet", 32'(oLocked), 0);
    frame(-1, 1'b0);
    check("resume_locked", 32'(oLocked), 1);

    // reset mid-frame while locked
    for (int l = 0; l < 3; l++) line(P, 1'b0);
    err_snap = err_pulses;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_all_zero("midreset");
    @(negedge Clock);
    Reset = 1'b0;
    check("midreset_no_err", 32'(err_pulses), 32'(err_snap));
    for (int l = 3; l < L; l++) line(P, l == L - 1);  // first Vsync fall after reset
    frame(-1, 1'b0);                                   // second
    check("post_reset_not_yet", 32'(oLocked), 0);
    frame(-1, 1'b0);                                   // third
    check("post_reset_locked", 32'(oLocked), 1);
    check("post_reset_latency", 32'(lock_rise_cyc - vs_drive_cyc), 4);
    check("post_reset_no_err", 32'(err_pulses), 32'(err_snap));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
